// File: rtl/debouncer_bank.sv
// Multi-channel push-button/switch debouncer: per-channel synchroniser, tick-gated stability filter,
// registered level plus rise/fall pulses. Define DEBOUNCER_BANK_REPEAT_EN to add hold-to-repeat pulses.
module debouncer_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                sampleTick,
  input  logic [CHANNELS-1:0] signalInput,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] risePulse,
  output logic [CHANNELS-1:0] fallPulse,
  output logic [CHANNELS-1:0] repeatPulse
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] syncChain [CHANNELS];
  logic [CNT_W-1:0]       stableCnt [CHANNELS];
  logic [CHANNELS-1:0]    syncOut;
  logic [CHANNELS-1:0]    accept;

  // Any tick that agrees with the current level restarts the window.
  function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] c, input logic differ);
    return differ ? c + 1'b1 : '0;
  endfunction

  always_comb begin
    syncOut = '0;
    accept  = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      syncOut[ch] = syncChain[ch][SYNC_STAGES-1];
      accept[ch]  = sampleTick && (syncOut[ch] != level[ch]) && (stableCnt[ch] == CNT_LAST);
    end
  end

  // Synchroniser stages and stability filter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        syncChain[ch] <= '0;
        stableCnt[ch] <= '0;
      end
      level     <= '0;
      risePulse <= '0;
      fallPulse <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        syncChain[ch] <= {syncChain[ch][SYNC_STAGES-2:0], signalInput[ch]};
        risePulse[ch] <= accept[ch] & syncOut[ch];
        fallPulse[ch] <= accept[ch] & ~syncOut[ch];
        if (sampleTick) begin
          if (accept[ch]) begin
            level[ch]     <= syncOut[ch];
            stableCnt[ch] <= '0;
          end else begin
            stableCnt[ch] <= nextCount(stableCnt[ch], syncOut[ch] != level[ch]);
          end
        end
      end
    end
  end

`ifdef DEBOUNCER_BANK_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0]    repCnt [CHANNELS];
  logic [CHANNELS-1:0] repPeriodic;

  // Repeat stage: first interval is the delay, later ones the period
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) repCnt[ch] <= '0;
      repPeriodic <= '0;
      repeatPulse <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        repeatPulse[ch] <= 1'b0;
        if (sampleTick) begin
          if (!level[ch] || accept[ch]) begin
            repCnt[ch]      <= '0;
            repPeriodic[ch] <= 1'b0;
          end else if (repCnt[ch] == (repPeriodic[ch] ? PERIOD_LAST : DELAY_LAST)) begin
            repCnt[ch]      <= '0;
            repPeriodic[ch] <= 1'b1;
            repeatPulse[ch] <= 1'b1;
          end else begin
            repCnt[ch] <= repCnt[ch] + 1'b1;
          end
        end
      end
    end
  end
`else
  assign repeatPulse = '0;
`endif

endmodule
